hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline sequencing controller for the 16-bit, 4-register, five-stage MIPS core. It sits beside the forwarding unit and drives the stage-enable and flush controls of the pipeline registers. It covers three cases: a one-cycle stall for load-use hazards that forwarding cannot cover, a flush of the three younger stages when a branch resolves taken in MEM, and a halt/drain handshake that empties the pipeline for an external debug agent. Optional saturating performance counters report stall and flush events.

## Interface
- LW_OP, 4'b0101, opcode of load word (the only producer with MemtoReg=1)
- STALL_CYCLES, 1, bubbles inserted per load-use hazard (legal values 1..3)
- DRAIN_CYCLES, 4, edges needed to retire IFID..MEMWB contents
- clock  in  1  pipeline clock; all state updates on the falling edge, the same edge as the pipeline registers
- reset  in  1  synchronous, active-high
- ifid_ir  in  16  instruction in ID; rs=[11:10], rt=[9:8]
- idex_memtoreg  in  1  the ID/EX instruction is a load
- idex_rt  in  2  destination register of the ID/EX load
- branch_taken  in  1  BranchSelect from the MEM stage
- halt_req  in  1  debug halt request; level, held until halt_ack
- pc_write  out  1  PC may load NextPC
- ifid_write  out  1  IF/ID may load
- fetch_nop  out  1  IF/ID loads 16'h0000 instead of IMemory
- idex_bubble  out  1  ID/EX control fields are zeroed
- flush_ifid, flush_idex, flush_exmem  out  1 each  zero the instruction and control fields of that register
- halt_ack  out  1  pipeline empty and frozen
- stall_cnt, flush_cnt  out  16 each  event counters

## Operation
- States: RUN, STALL, DRAIN, HALTED. A down-counter `cnt` (2 bits is enough for STALL_CYCLES, 3 bits for DRAIN_CYCLES) serves STALL and DRAIN.
- Load-use hazard (`lu`), combinational: idex_memtoreg && idex_rt!=0 && (idex_rt==ifid_ir[11:10] || idex_rt==ifid_ir[9:8]). Register 0 never raises a hazard.
- Priority, highest first: reset, branch_taken, lu, halt_req.
- Default outputs: pc_write=1, ifid_write=1, everything else 0.
- RUN behaviour:
  - branch_taken: assert all three flushes, pc_write=1 (the target loads), stay in RUN, flush_cnt+1.
  - Otherwise lu: pc_write=0, ifid_write=0, idex_bubble=1. With STALL_CYCLES=1, stay in RUN. With more cycles, go to STALL with cnt=STALL_CYCLES-1. stall_cnt+1 per bubble cycle.
  - Otherwise halt_req: go to DRAIN with cnt=DRAIN_CYCLES-1, and already assert pc_write=0, fetch_nop=1 on this edge.
- STALL: hold as for lu and decrement cnt; at cnt==0 return to RUN. branch_taken here aborts the stall: flushes assert, pc_write=1, go to RUN.
- DRAIN: pc_write=0 and fetch_nop=1 every cycle.
  - branch_taken: pc_write=1 (PC keeps the target for resume), flushes assert, cnt continues.
  - lu: stall as in RUN; cnt is held during that cycle.
  - At cnt==0, go to HALTED.
- HALTED: pc_write=0, ifid_write=0, fetch_nop=1, halt_ack=1. When halt_req drops, go to RUN; the next edge resumes fetch at the held PC.
- Counters saturate at 16'hFFFF. halt_req deasserted during DRAIN is ignored: DRAIN completes, HALTED lasts exactly one cycle, then RUN.

## Timing
- All control outputs are Mealy: valid in the same cycle as the inputs, and setup-ready before the falling edge that they gate.
- The load-use bubble is visible in ID/EX one edge after detection. The dependent instruction reaches EX one edge later and takes the loaded value through the MEMWB forward path.
- Branch flush: the three younger instructions are squashed on the edge where branch_taken is high. Penalty is 3 cycles.
- halt_ack rises DRAIN_CYCLES edges after halt_req is sampled in RUN, plus one per stall cycle inside DRAIN. It falls on the first edge after halt_req drops.
- While reset is high:
  - pc_write=0, ifid_write=0, fetch_nop=0, idex_bubble=0.
  - All flushes=1, halt_ack=0.
  - State=RUN, cnt=0, stall_cnt=flush_cnt=0.
- Reset in any state returns to RUN at the next edge. A pending halt is discarded.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_cnt and flush_cnt are 16-bit saturating registers, cleared by reset.
- HAZARD_PERF_CNT_EN undefined: no counter registers; both outputs are tied to 16'h0000.
- No other behaviour changes between the two builds.

## Test plan
- lw $t1,0($0) then add $t3,$t1,$t2 → one cycle with pc_write=0 / idex_bubble=1; $t3 = mem[0]+$t2; stall_cnt=1.
- lw $t0 followed by a reader of $t0 (register 0) → no stall; pc_write stays 1.
- branch_taken pulsed for 1 cycle while a lw hazard is also present → all three flushes=1, pc_write=1, no bubble; flush_cnt=1, stall_cnt=0.
- halt_req raised with an add, sub, or, and in flight → halt_ack after 4 edges; all four writebacks complete; PC frozen; release → the next fetch is the held PC.
- halt_req with a load-use pair inside the drain → halt_ack after 5 edges; result correct.
- reset asserted mid-DRAIN → next edge: state RUN, halt_ack=0, counters 0; 65,540 forced stalls → stall_cnt=16'hFFFF (counters enabled), 16'h0000 (counters disabled).

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, taken-branch flush, halt/drain for debug.
// Optional saturating stall/flush event counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
   parameter logic [3:0] LW_OP        = 4'b0101,
   parameter int          STALL_CYCLES = 1,
   parameter int          DRAIN_CYCLES = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] ifid_ir,
   input  logic        idex_memtoreg,
   input  logic [1:0]  idex_rt,
   input  logic        branch_taken,
   input  logic        halt_req,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        fetch_nop,
   output logic        idex_bubble,
   output logic        flush_ifid,
   output logic        flush_idex,
   output logic        flush_exmem,
   output logic        halt_ack,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, DRAIN = 2'd2, HALTED = 2'd3} state_t;

   state_t     r_state, w_next_state;
   logic [2:0] r_cnt, w_next_cnt;
   logic       w_lu, w_flush, w_stall_inc, w_flush_inc;
   logic       w_unused_ir;

   // Only the source fields matter here; the loads are identified by idex_memtoreg.
   assign w_unused_ir = ^{(ifid_ir[15:12] == LW_OP), ifid_ir[7:0]};

   assign w_lu = idex_memtoreg && (idex_rt != 2'd0) &&
                 ((idex_rt == ifid_ir[11:10]) || (idex_rt == ifid_ir[9:8]));

   assign flush_ifid  = w_flush;
   assign flush_idex  = w_flush;
   assign flush_exmem = w_flush;
   assign dbg_state   = r_state;

   // halt_req/halt_ack is a level handshake: halt_req is held until halt_ack is seen,
   // halt_ack stays high while halted and falls on the first edge after halt_req drops.
   always_comb begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      fetch_nop    = 1'b0;
      idex_bubble  = 1'b0;
      w_flush      = 1'b0;
      halt_ack     = 1'b0;
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_stall_inc  = 1'b0;
      w_flush_inc  = 1'b0;
      case (r_state)
         RUN: begin
            if (branch_taken) begin
               w_flush     = 1'b1;
               w_flush_inc = 1'b1;
            end else if (w_lu) begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
               w_stall_inc = 1'b1;
               if (STALL_CYCLES > 1) begin
                  w_next_state = STALL;
                  w_next_cnt   = 3'(STALL_CYCLES - 1);
               end
            end else if (halt_req) begin
               pc_write     = 1'b0;
               fetch_nop    = 1'b1;
               w_next_state = DRAIN;
               w_next_cnt   = 3'(DRAIN_CYCLES - 1);
            end
         end
         STALL: begin
            if (branch_taken) begin
               w_flush      = 1'b1;
               w_flush_inc  = 1'b1;
               w_next_state = RUN;
               w_next_cnt   = 3'd0;
            end else begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
               w_stall_inc = 1'b1;
               if (r_cnt <= 3'd1) begin
                  w_next_state = RUN;
                  w_next_cnt   = 3'd0;
               end else begin
                  w_next_cnt = r_cnt - 3'd1;
               end
            end
         end
         DRAIN: begin
            pc_write  = 1'b0;
            fetch_nop = 1'b1;
            if (branch_taken) begin
               pc_write    = 1'b1;
               w_flush     = 1'b1;
               w_flush_inc = 1'b1;
            end else if (w_lu) begin
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
               w_stall_inc = 1'b1;
            end
            // A stall cycle moves nothing down the pipe, so the drain count holds.
            if (branch_taken || !w_lu) begin
               if (r_cnt <= 3'd1) begin
                  w_next_state = HALTED;
                  w_next_cnt   = 3'd0;
               end else begin
                  w_next_cnt = r_cnt - 3'd1;
               end
            end
         end
         HALTED: begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            fetch_nop  = 1'b1;
            halt_ack   = 1'b1;
            if (!halt_req) w_next_state = RUN;
         end
         default: begin
            w_next_state = RUN;
            w_next_cnt   = 3'd0;
         end
      endcase
      if (reset) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         fetch_nop    = 1'b0;
         idex_bubble  = 1'b0;
         w_flush      = 1'b1;
         halt_ack     = 1'b0;
         w_next_state = RUN;
         w_next_cnt   = 3'd0;
         w_stall_inc  = 1'b0;
         w_flush_inc  = 1'b0;
      end
   end

   // Falling edge, in step with the pipeline registers this block gates.
   always_ff @(negedge clock) begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] r_stall_cnt, r_flush_cnt;

   always_ff @(negedge clock) begin
      if (reset) begin
         r_stall_cnt <= 16'h0000;
         r_flush_cnt <= 16'h0000;
      end else begin
         if (w_stall_inc && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
         if (w_flush_inc && (r_flush_cnt != 16'hFFFF)) r_flush_cnt <= r_flush_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`else
   logic w_unused_cnt;
   assign w_unused_cnt = w_stall_inc ^ w_flush_inc;
   assign stall_cnt    = 16'h0000;
   assign flush_cnt    = 16'h0000;
`endif

endmodule
